// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART with 16x oversampled receiver, RX and TX FIFOs, one shared tick.
// All logic runs on CLK_50MHZ with asynchronous active-high RST.
// Optional feature macro: UART_PARITY_EN. When defined, an even-parity bit follows the
// data bits on TX and is checked on RX. When undefined, frames are start+DATA_W+stop
// and PARITY_ERR is tied 0.
module uart_fifo_core #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV        = 27,
    parameter int STOP_BITS  = 1
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              RX,
    output logic              TX,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              WR_EN,
    output logic              TX_FULL,
    output logic              TX_BUSY,
    output logic [DATA_W-1:0] DATA_OUT,
    input  logic              RD_EN,
    output logic              RX_EMPTY,
    output logic              RX_OVERRUN,
    output logic              FRAME_ERR,
    output logic              PARITY_ERR
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wr_ptr, tx_rd_ptr;
    logic              tx_empty, tx_full, tx_pop, tx_do_push;
    logic [DATA_W-1:0] tx_head;

    assign tx_empty   = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full    = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                        (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
    // A push into a full FIFO is accepted only when the serialiser pops on the same cycle.
    assign tx_do_push = WR_EN && (!tx_full || tx_pop);
    assign tx_head    = tx_mem[tx_rd_ptr[AW-1:0]];

    // TX FIFO storage write.
    // NOTE: FIFO storage is deliberately not reset; pointers define validity, and
    // resetting the array would only turn cheap RAM into a wide flop bank.
    always_ff @(posedge CLK_50MHZ) begin
        if (tx_do_push) tx_mem[tx_wr_ptr[AW-1:0]] <= DATA_IN;
    end

    // TX FIFO pointers; tx_pop is only raised when the FIFO is non-empty.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_do_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)     tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick, shared by RX and TX
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == DIV_W'(DIV - 1));

    // Free-running divider; reloaded at a TX pop so TX bit edges are exact.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST)                 tick_cnt <= '0;
        else if (tx_pop || tick) tick_cnt <= '0;
        else                     tick_cnt <= tick_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    logic [2:0]        tx_state;
    logic [3:0]        tx_cnt;
    logic [3:0]        tx_bit;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_q;
    logic              tx_bit_end, tx_last_stop;
`ifdef UART_PARITY_EN
    logic              tx_par;
`endif

    assign tx_bit_end   = tick && (tx_cnt == 4'd15);
    assign tx_last_stop = (tx_state == S_STOP) && tx_bit_end && (tx_bit == 4'(STOP_BITS - 1));
    // Pop from IDLE, or straight out of the last stop bit so back-to-back frames have no gap.
    assign tx_pop       = !tx_empty && ((tx_state == S_IDLE) || tx_last_stop);

    // TX state machine: each bit lasts 16 ticks counted from the pop.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            if (tick) tx_cnt <= tx_cnt + 1'b1;
            if (tx_pop) begin
                tx_state <= S_START;
                tx_cnt   <= '0;
                tx_bit   <= '0;
                tx_shift <= tx_head;
`ifdef UART_PARITY_EN
                tx_par   <= ^tx_head;
`endif
            end else if (tx_bit_end) begin
                case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx_bit   <= '0;
                    end
                    S_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        if (tx_bit == 4'(DATA_W - 1)) begin
                            tx_bit   <= '0;
`ifdef UART_PARITY_EN
                            tx_state <= S_PARITY;
`else
                            tx_state <= S_STOP;
`endif
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        tx_state <= S_STOP;
                        tx_bit   <= '0;
                    end
`endif
                    S_STOP: begin
                        if (tx_bit == 4'(STOP_BITS - 1)) tx_state <= S_IDLE;
                        else                             tx_bit   <= tx_bit + 1'b1;
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end

    // Registered line driver: follows the state one cycle later, glitch-free.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            tx_q <= 1'b1;
        end else begin
            case (tx_state)
                S_START:  tx_q <= 1'b0;
                S_DATA:   tx_q <= tx_shift[0];
`ifdef UART_PARITY_EN
                S_PARITY: tx_q <= tx_par;
`endif
                default:  tx_q <= 1'b1;
            endcase
        end
    end

    assign TX      = tx_q;
    assign TX_FULL = tx_full;
    assign TX_BUSY = (tx_state != S_IDLE) || !tx_empty;

    // ------------------------------------------------------------------
    // RX synchroniser and deserialiser
    // ------------------------------------------------------------------
    logic              rx_s1, rx_s2, rx_prev;
    logic [2:0]        rx_state;
    logic [3:0]        rx_cnt;
    logic [3:0]        rx_bit;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_fall, rx_mid, rx_stop_mid, rx_push;
`ifdef UART_PARITY_EN
    logic              rx_par;
`endif

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall     = rx_prev && !rx_s2;
    // Sample count wraps every 16 ticks, so count 7 is mid-bit for every bit.
    assign rx_mid      = tick && (rx_cnt == 4'd7);
    assign rx_stop_mid = (rx_state == S_STOP) && rx_mid;
    assign rx_push     = rx_stop_mid && rx_s2;

    // RX state machine: start validated at mid-bit, then one sample per bit.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_par   <= 1'b0;
`endif
        end else begin
            if (tick) rx_cnt <= rx_cnt + 1'b1;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_fall) rx_state <= S_START;
                end
                S_START: begin
                    rx_bit <= '0;
                    if (rx_mid) rx_state <= rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (rx_mid) begin
                        rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
                        if (rx_bit == 4'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_mid) begin
                        rx_par   <= rx_s2;
                        rx_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (rx_mid) rx_state <= S_IDLE;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       rx_wr_ptr, rx_rd_ptr;
    logic              rx_empty, rx_full, rx_do_push, rx_do_pop;

    assign rx_empty   = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full    = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                        (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
    assign rx_do_pop  = RD_EN && !rx_empty;
    assign rx_do_push = rx_push && (!rx_full || rx_do_pop);

    // RX FIFO storage write.
    always_ff @(posedge CLK_50MHZ) begin
        if (rx_do_push) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_shift;
    end

    // RX FIFO pointers.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_do_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_do_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // Head is forced to 0 while empty so DATA_OUT is clean out of reset.
    assign DATA_OUT = rx_empty ? '0 : rx_mem[rx_rd_ptr[AW-1:0]];
    assign RX_EMPTY = rx_empty;

    // Error pulses, registered so they line up with the RX_EMPTY update.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            FRAME_ERR  <= 1'b0;
            RX_OVERRUN <= 1'b0;
`ifdef UART_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            FRAME_ERR  <= rx_stop_mid && !rx_s2;
            RX_OVERRUN <= rx_push && rx_full && !RD_EN;
`ifdef UART_PARITY_EN
            PARITY_ERR <= rx_stop_mid && (^{rx_shift, rx_par});
`endif
        end
    end

`ifndef UART_PARITY_EN
    assign PARITY_ERR = 1'b0;
`endif

endmodule
